divisor_seq: RTL and testbench



---
 rtl/divisor_seq.sv | 151 +++++++++++++++
 tb/tb_divisor_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_seq.sv
// Sequential restoring divider: one quotient bit per clock, one-cycle done pulse, divide-by-zero flag.
// Optional DIVISOR_SEQ_AUTOREPEAT_EN: restart straight from DONE while init stays high.
module divisor_seq #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] DV,
    input  logic [WIDTH-1:0] DR,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] R,
    output logic             done,
    output logic             busy,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_init_d;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_zero;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_r;
    logic             r_done;
    logic             r_busy;
    logic             r_err;

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH:0]   w_q_ext;
    logic             w_rise;

    assign C    = r_c;
    assign R    = r_r;
    assign done = r_done;
    assign busy = r_busy;
    assign err  = r_err;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_shift    = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
        w_ge       = (w_shift >= {1'b0, r_div});
        w_rem_next = w_shift;
        if (w_ge) begin
            w_rem_next = w_shift - {1'b0, r_div};
        end else begin
            w_rem_next = w_shift;
        end
        w_q_ext = {r_q, w_ge};
        w_rise  = init & ~r_init_d;
    end

    // Divider FSM with registered results; DONE publishes results on its exit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_init_d <= 1'b0;
            r_q      <= '0;
            r_div    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_zero   <= 1'b0;
            r_c      <= '0;
            r_r      <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_init_d <= init;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    // r_busy still set here means this is the done cycle, where new requests are dropped.
                    if (w_rise && !r_busy) begin
                        r_busy <= 1'b1;
                        if (DR == '0) begin
                            r_q     <= '1;
                            r_rem   <= {1'b0, DV};
                            r_zero  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_q     <= DV;
                            r_div   <= DR;
                            r_rem   <= '0;
                            r_cnt   <= CW'(WIDTH);
                            r_zero  <= 1'b0;
                            r_state <= S_CALC;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_q   <= w_q_ext[WIDTH-1:0];
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_CALC;
                    end
                end
                S_DONE: begin
                    r_c    <= r_q;
                    r_r    <= r_rem[WIDTH-1:0];
                    r_err  <= r_zero;
                    r_done <= 1'b1;
`ifdef DIVISOR_SEQ_AUTOREPEAT_EN
                    if (init) begin
                        if (DR == '0) begin
                            r_q     <= '1;
                            r_rem   <= {1'b0, DV};
                            r_zero  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_q     <= DV;
                            r_div   <= DR;
                            r_rem   <= '0;
                            r_cnt   <= CW'(WIDTH);
                            r_zero  <= 1'b0;
                            r_state <= S_CALC;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_seq.sv
// Directed self-checking bench for divisor_seq (WIDTH=3, autorepeat disabled).
module tb_divisor_seq;

    logic       clk;
    logic       rst;
    logic       init;
    logic [2:0] DV;
    logic [2:0] DR;
    logic [2:0] C;
    logic [2:0] R;
    logic       done;
    logic       busy;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    divisor_seq #(.WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .init(init),
        .DV  (DV),
        .DR  (DR),
        .C   (C),
        .R   (R),
        .done(done),
        .busy(busy),
        .err (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise init, wait for done (bounded), drop init and return to idle.
    task automatic run_op(input logic [2:0] dv, input logic [2:0] dr, output int lat,
                          output logic [2:0] c, output logic [2:0] r, output logic e);
        DV   = dv;
        DR   = dr;
        init = 1'b1;
        tick();
        lat = 0;
        while (!done && lat < 12) begin
            tick();
            lat++;
        end
        c = C;
        r = R;
        e = err;
        init = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; init = 1'b0; DV = 3'd0; DR = 3'd0;
        tick(); tick();
        n_tests++;
        if ({C, R, done, busy, err} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_state: got C=%0d R=%0d done=%b busy=%b err=%b, want all 0", C, R, done, busy, err);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_basic();
        DV = 3'd7; DR = 3'd2; init = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_start: got busy=%b done=%b, want 1 0", busy, done);
        end
        DV = 3'd1; DR = 3'd1;
        tick(); tick(); tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_early: at start+3 got done=%b busy=%b, want 0 1", done, busy);
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b1 || C !== 3'd3 || R !== 3'd1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got done=%b busy=%b C=%0d R=%0d err=%b, want 1 1 3 1 0", done, busy, C, R, err);
        end
        init = 1'b0;
        tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || C !== 3'd3 || R !== 3'd1) begin
            n_fail++;
            $display("FAIL basic_hold: got done=%b busy=%b C=%0d R=%0d, want 0 0 3 1", done, busy, C, R);
        end
        tick();
    endtask

    task automatic test_more();
        int lat; logic [2:0] c, r; logic e;
        run_op(3'd6, 3'd3, lat, c, r, e);
        n_tests++;
        if (lat !== 4 || c !== 3'd2 || r !== 3'd0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL div_6_3: got lat=%0d C=%0d R=%0d err=%b, want 4 2 0 0", lat, c, r, e);
        end
        run_op(3'd3, 3'd7, lat, c, r, e);
        n_tests++;
        if (lat !== 4 || c !== 3'd0 || r !== 3'd3 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL div_3_7: got lat=%0d C=%0d R=%0d err=%b, want 4 0 3 0", lat, c, r, e);
        end
    endtask

    task automatic test_div_zero();
        int lat; logic [2:0] c, r; logic e;
        run_op(3'd5, 3'd0, lat, c, r, e);
        n_tests++;
        if (lat !== 1 || c !== 3'd7 || r !== 3'd5 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL div_by_zero: got lat=%0d C=%0d R=%0d err=%b, want 1 7 5 1", lat, c, r, e);
        end
        run_op(3'd4, 3'd2, lat, c, r, e);
        n_tests++;
        if (lat !== 4 || c !== 3'd2 || r !== 3'd0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL after_zero: got lat=%0d C=%0d R=%0d err=%b, want 4 2 0 0", lat, c, r, e);
        end
    endtask

    task automatic test_hold_high();
        int pulses = 0;
        logic [2:0] c = 3'd0, r = 3'd0;
        DV = 3'd7; DR = 3'd3; init = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) begin
                pulses++;
                c = C;
                r = R;
            end
        end
        init = 1'b0;
        tick(); tick();
        n_tests++;
        if (pulses !== 1 || c !== 3'd2 || r !== 3'd1) begin
            n_fail++;
            $display("FAIL hold_high: got pulses=%0d C=%0d R=%0d, want 1 2 1", pulses, c, r);
        end
    endtask

    task automatic test_reset_abort();
        int lat = 0;
        int stray = 0;
        DV = 3'd7; DR = 3'd2; init = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || C !== 3'd0 || R !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_reset: got busy=%b done=%b C=%0d R=%0d, want 0 0 0 0", busy, done, C, R);
        end
        tick();
        if (done) stray++;
        rst = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_after_reset: got busy=%b, want 1", busy);
        end
        while (!done && lat < 12) begin
            tick();
            lat++;
        end
        n_tests++;
        if (lat !== 4 || C !== 3'd3 || R !== 3'd1 || stray !== 0) begin
            n_fail++;
            $display("FAIL restart_result: got lat=%0d C=%0d R=%0d stray=%0d, want 4 3 1 0", lat, C, R, stray);
        end
        init = 1'b0;
        tick(); tick();
    endtask

    task automatic test_sweep();
        int lat, el; logic [2:0] c, r, ec, er; logic e, ee;
        for (int dv = 0; dv < 8; dv++) begin
            for (int dr = 0; dr < 8; dr++) begin
                if (dr == 0) begin
                    ec = 3'd7; er = dv[2:0]; ee = 1'b1; el = 1;
                end else begin
                    ec = 3'(dv / dr); er = 3'(dv % dr); ee = 1'b0; el = 4;
                end
                run_op(dv[2:0], dr[2:0], lat, c, r, e);
                n_tests++;
                if (lat !== el || c !== ec || r !== er || e !== ee) begin
                    n_fail++;
                    $display("FAIL sweep_%0d_%0d: got lat=%0d C=%0d R=%0d err=%b, want %0d %0d %0d %b",
                             dv, dr, lat, c, r, e, el, ec, er, ee);
                end
            end
        end
        tick(); tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_done: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_more();
        test_div_zero();
        test_hold_high();
        test_reset_abort();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
